// File: rtl/patch_scan_ctrl_pkg.sv
// Shared types and constants for the patch scan sequencer.
// Legal (patch, stride) pairs live in one lookup table.
package patch_scan_ctrl_pkg;

  localparam int CNT_W    = 6;
  localparam int PIPE_LAT = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC_X, S_CALC_Y, S_SCAN, S_DRAIN, S_DONE, S_ERR
  } state_t;

  // Indexed by patch size; each bit set marks a legal stride for that patch.
  localparam logic [7:0][7:0] LEGAL_CFG = {
    8'hFE, 8'h00, 8'h3E, 8'h00, 8'h0E, 8'h00, 8'h00, 8'h00
  };

  function automatic logic cfg_legal(input logic [2:0] p, input logic [2:0] s);
    return LEGAL_CFG[p][s];
  endfunction

endpackage

// File: rtl/patch_scan_ctrl_div.sv
// Sequential divider: one subtraction per clock, so a quotient q takes q+1 clocks.
// o_done pulses for one clock and o_quot stays valid until the next start.
module seq_sub_div
  import patch_scan_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_dividend,
  input  logic [2:0]       i_divisor,
  output logic             o_done,
  output logic [CNT_W-1:0] o_quot
);

  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] r_quot;
  logic [2:0]       r_div;
  logic             r_busy;
  logic             r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_div  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= i_dividend;
        r_quot <= '0;
        r_div  <= i_divisor;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (r_rem >= {{(CNT_W-3){1'b0}}, r_div}) begin
          r_rem  <= r_rem - {{(CNT_W-3){1'b0}}, r_div};
          r_quot <= r_quot + 1'b1;
        end else begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_quot = r_quot;

endmodule

// File: rtl/patch_scan_ctrl.sv
// Patch scan sequencer: computes patch counts per axis, then sweeps x per row group
// and emits x index/valid aligned to the downstream generator's pipeline latency.
module patch_scan_ctrl
  import patch_scan_ctrl_pkg::*;
#(
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 28,
  parameter int LANES  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [2:0]       i_patch_size,
  input  logic [2:0]       i_stride,
  input  logic             i_done_in,
  output logic [CNT_W-1:0] o_cycle_counts,
  output logic             o_en,
  output logic [CNT_W-1:0] o_x_idx,
  output logic [CNT_W-1:0] o_x_idx_al,
  output logic             o_x_valid_al,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic             o_cfg_err
);

  state_t r_state, w_next;

  logic [2:0]       r_p, r_s;
  logic [CNT_W-1:0] r_bx, r_ny, r_cc, r_x;
  logic [1:0]       r_dcnt;

  logic             w_legal, w_div_start, w_div_done, w_last_x, w_en;
  logic [CNT_W-1:0] w_dividend, w_quot, w_axis_cnt, w_ny;
  logic [2:0]       w_divisor;

  logic [PIPE_LAT-1:0][CNT_W-1:0] r_x_pipe;
  logic [PIPE_LAT-1:0]            r_vld_pipe;

  assign w_legal    = cfg_legal(i_patch_size, i_stride);
  assign w_last_x   = (r_x == r_bx - 1'b1);
  assign w_axis_cnt = w_quot + 1'b1;
  assign w_ny       = CNT_W'((7'(w_axis_cnt) + 7'(LANES - 1)) / 7'(LANES));

  // The divider runs X straight from the inputs in IDLE, then Y from the latched patch.
  assign w_div_start = ((r_state == S_IDLE) && i_start && w_legal) ||
                       ((r_state == S_CALC_X) && w_div_done);
  assign w_dividend  = (r_state == S_IDLE) ? CNT_W'(WIDTH)  - CNT_W'(i_patch_size)
                                           : CNT_W'(HEIGHT) - CNT_W'(r_p);
  assign w_divisor   = (r_state == S_IDLE) ? i_stride : r_s;

  seq_sub_div u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend (w_dividend),
    .i_divisor  (w_divisor),
    .o_done     (w_div_done),
    .o_quot     (w_quot)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = w_legal ? S_CALC_X : S_ERR;
      S_CALC_X: if (w_div_done) w_next = S_CALC_Y;
      S_CALC_Y: if (w_div_done) w_next = S_SCAN;
      S_SCAN:   if (w_last_x && ((r_cc == r_ny) || i_done_in)) w_next = S_DRAIN;
      S_DRAIN:  if (r_dcnt == 2'(PIPE_LAT - 1)) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      S_ERR:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // A rejected config only pulses cfg_err; it never counts as busy.
  always_comb begin
    w_en         = (r_state == S_SCAN);
    o_busy       = (r_state != S_IDLE) && (r_state != S_ERR);
    o_frame_done = (r_state == S_DONE);
    o_cfg_err    = (r_state == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p    <= '0;
      r_s    <= '0;
      r_bx   <= '0;
      r_ny   <= '0;
      r_cc   <= '0;
      r_x    <= '0;
      r_dcnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start && w_legal) begin
          r_p <= i_patch_size;
          r_s <= i_stride;
        end
        S_CALC_X: if (w_div_done) r_bx <= w_axis_cnt;
        S_CALC_Y: if (w_div_done) begin
          r_ny <= w_ny;
          r_cc <= CNT_W'(1);
          r_x  <= '0;
        end
        S_SCAN: begin
          r_dcnt <= '0;
          if (w_last_x) begin
            if ((r_cc != r_ny) && !i_done_in) begin
              r_x  <= '0;
              r_cc <= r_cc + 1'b1;
            end
          end else begin
            r_x <= r_x + 1'b1;
          end
        end
        S_DRAIN: r_dcnt <= r_dcnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_pipe   <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_x_pipe   <= {r_x_pipe[PIPE_LAT-2:0], r_x};
      r_vld_pipe <= {r_vld_pipe[PIPE_LAT-2:0], w_en};
    end
  end

  assign o_en           = w_en;
  assign o_cycle_counts = r_cc;
  assign o_x_idx        = r_x;
  assign o_x_idx_al     = r_x_pipe[PIPE_LAT-1];
  assign o_x_valid_al   = r_vld_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_patch_scan_ctrl.sv
// Directed bench for patch_scan_ctrl at W=H=28, LANES=8.
module tb_patch_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, done_in;
  logic [2:0] p, s;
  logic [5:0] cc, x, x_al;
  logic       en, x_val_al, busy, fd, cfg_err;

  always #5 clk = ~clk;

  patch_scan_ctrl #(.WIDTH(28), .HEIGHT(28), .LANES(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (start),
    .i_patch_size   (p),
    .i_stride       (s),
    .i_done_in      (done_in),
    .o_cycle_counts (cc),
    .o_en           (en),
    .o_x_idx        (x),
    .o_x_idx_al     (x_al),
    .o_x_valid_al   (x_val_al),
    .o_busy         (busy),
    .o_frame_done   (fd),
    .o_cfg_err      (cfg_err)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Monitor: running totals sampled on the falling edge, plus a reference delay line.
  int   cyc = 0, en_tot = 0, fd_tot = 0, cfg_tot = 0, busy_tot = 0, align_err = 0;
  int   last_en_cyc = 0, fd_cyc = 0;
  int   rise_cc = 0, run_max_cc = 0;
  logic en_prev = 1'b0;
  logic [2:0]      h_v = '0;
  logic [2:0][5:0] h_x = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      h_v     <= '0;
      h_x     <= '0;
      en_prev <= 1'b0;
    end else begin
      if (x_val_al !== h_v[2] || x_al !== h_x[2]) align_err <= align_err + 1;
      h_v     <= {h_v[1:0], en};
      h_x     <= {h_x[1:0], x};
      en_prev <= en;
      if (en) begin
        en_tot      <= en_tot + 1;
        last_en_cyc <= cyc;
        if (!en_prev) begin
          rise_cc    <= int'(cc);
          run_max_cc <= int'(cc);
        end else if (int'(cc) > run_max_cc) begin
          run_max_cc <= int'(cc);
        end
      end
      if (fd) begin
        fd_tot <= fd_tot + 1;
        fd_cyc <= cyc;
      end
      if (cfg_err) cfg_tot  <= cfg_tot + 1;
      if (busy)    busy_tot <= busy_tot + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] ps, input logic [2:0] ss);
    p = ps; s = ss; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    chk({tag, "_finish"}, n < 2000, 1);
    repeat (2) tick();
  endtask

  task automatic wait_pos(input string tag, input logic [5:0] wcc, input logic [5:0] wx);
    int n = 0;
    while (!(en && cc == wcc && x == wx) && n < 2000) begin tick(); n++; end
    chk({tag, "_reach"}, n < 2000, 1);
  endtask

  // One full scan; checks en count, cycle_counts range, final x and a single frame_done.
  task automatic run_scan(input string tag, input logic [2:0] ps, input logic [2:0] ss,
                          input int exp_en, input int exp_ny, input int exp_lastx);
    int b_en, b_fd;
    b_en = en_tot; b_fd = fd_tot;
    do_start(ps, ss);
    wait_idle(tag);
    chk({tag, "_en_cnt"}, en_tot - b_en, exp_en);
    chk({tag, "_cc_first"}, rise_cc, 1);
    chk({tag, "_cc_max"}, run_max_cc, exp_ny);
    chk({tag, "_x_last"}, x, exp_lastx);
    chk({tag, "_frame_done"}, fd_tot - b_fd, 1);
  endtask

  task automatic run_bad(input string tag, input logic [2:0] ps, input logic [2:0] ss);
    int b_en, b_cfg, b_busy;
    b_en = en_tot; b_cfg = cfg_tot; b_busy = busy_tot;
    do_start(ps, ss);
    repeat (5) tick();
    chk({tag, "_cfg_err"}, cfg_tot - b_cfg, 1);
    chk({tag, "_busy"}, busy_tot - b_busy, 0);
    chk({tag, "_en"}, en_tot - b_en, 0);
  endtask

  initial begin
    int b_en, b_fd;
    rst = 1'b1; start = 1'b0; done_in = 1'b0; p = 3'd3; s = 3'd1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_en", en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cc", cc, 0);
    chk("rst_x", x, 0);
    chk("rst_xval_al", x_val_al, 0);
    chk("rst_fd_cfg", {fd, cfg_err}, 0);

    run_scan("p3s1", 3'd3, 3'd1, 104, 4, 25);
    run_scan("p3s3", 3'd3, 3'd3, 18, 2, 8);
    run_scan("p7s7", 3'd7, 3'd7, 4, 1, 3);
    run_scan("p5s2", 3'd5, 3'd2, 24, 2, 11);

    run_bad("p3s4", 3'd3, 3'd4);
    run_bad("p4s1", 3'd4, 3'd1);
    run_bad("p5s0", 3'd5, 3'd0);

    // Early termination from the generator: finish the current row, then drain.
    b_en = en_tot; b_fd = fd_tot;
    do_start(3'd3, 3'd1);
    wait_pos("done_in", 6'd2, 6'd10);
    done_in = 1'b1;
    wait_idle("done_in");
    done_in = 1'b0;
    chk("done_in_en_cnt", en_tot - b_en, 52);
    chk("done_in_cc", cc, 2);
    chk("done_in_x", x, 25);
    chk("done_in_fd", fd_tot - b_fd, 1);
    chk("done_in_drain", fd_cyc - last_en_cyc, 4);

    // Reset in the middle of a scan.
    do_start(3'd3, 3'd1);
    wait_pos("midrst", 6'd3, 6'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_en", en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cc", cc, 0);
    chk("midrst_x", x, 0);
    chk("midrst_al", {x_val_al, x_al}, 0);
    chk("midrst_fd_cfg", {fd, cfg_err}, 0);
    tick();
    run_scan("rescan", 3'd3, 3'd1, 104, 4, 25);

    // A start during the scan must not disturb it or re-latch the config.
    b_en = en_tot; b_fd = fd_tot;
    do_start(3'd3, 3'd1);
    wait_pos("busystart", 6'd2, 6'd3);
    do_start(3'd7, 3'd7);
    wait_idle("busystart");
    chk("busystart_en_cnt", en_tot - b_en, 104);
    chk("busystart_cc_max", run_max_cc, 4);
    chk("busystart_x", x, 25);
    chk("busystart_fd", fd_tot - b_fd, 1);

    chk("align_err", align_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
